calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Sequences the four-function hex calculator datapath from decoded keypad events.
- Inputs are the single-cycle strobes from the keypad interpreter: newhex/hexcode, newop/opcode, eq, BS, CA, CE.
- Owns operand entry, operator latching, chained operations and the execute phase: single-cycle add/sub, multi-cycle shift-add multiply.
- Drives the value shown on the seven-segment display plus status flags.

Parameters:
- W, 16, operand/result width in bits; must be a multiple of 4.
- DIGITS, W/4, maximum hex digits accepted per operand.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- newhex  input  1  one-cycle strobe, hex digit key pressed.
- hexcode  input  4  digit value, valid when newhex=1.
- newop  input  1  one-cycle strobe, operator key pressed.
- opcode  input  2  00 add, 01 multiply, 10 subtract; 11 treated as add.
- eq  input  1  one-cycle strobe, equals pressed.
- BS  input  1  one-cycle strobe, backspace.
- CA  input  1  one-cycle strobe, clear all.
- CE  input  1  one-cycle strobe, clear entry.
- display  output  W  value to show: current entry, latched operand A, or result.
- busy  output  1  high while in EXEC.
- ovf  output  1  sticky overflow/borrow flag of the last operation.
- op_shown  output  2  latched pending operator.
- op_valid  output  1  high while an operator is pending (ENTER_B).
- state  output  2  00 ENTER_A, 01 ENTER_B, 10 EXEC, 11 RESULT.

Behaviour:
- Reset (rst_n=0, async):
  - All registers cleared; state=ENTER_A.
  - display=0, busy=0, ovf=0, op_shown=00, op_valid=0, digit count=0.
- All outputs are registered. A strobe at edge n is reflected at n+1.
- CA:
  - Accepted in every state, including mid-EXEC, where it aborts the operation.
  - Produces the reset state, ovf included.
  - CA has priority over every other strobe in the same cycle.
- Priority when several strobes are coincident: CA > CE > BS > eq > newop > newhex.
- ENTER_A:
  - newhex with count<DIGITS: entry={entry[W-5:0],hexcode}, count+1. With count=DIGITS the digit is ignored.
  - BS: entry>>4, count-1; no effect when count=0.
  - CE: entry=0, count=0.
  - newop: A=entry, op latched; entry=0, count=0; go to ENTER_B; op_valid=1.
  - eq: ignored.
  - display=entry.
- ENTER_B:
  - Digit, BS and CE handling on B entry is identical to ENTER_A.
  - display=A while count=0, else display=entry.
  - newop with count=0: replace the latched operator only.
  - newop with count>0: chained operation. Go to EXEC using the old op; set the chain flag and hold the new opcode.
  - eq: go to EXEC with B=entry (0 if no digits entered).
- EXEC (busy=1; all strobes except CA ignored):
  - Add: 1 cycle. result=(A+B) mod 2^W; ovf=carry out.
  - Subtract: 1 cycle. result=(A-B) mod 2^W; ovf=(A<B).
  - Multiply: exactly W cycles of shift-add on a 2W-bit product. result=low W bits; ovf=(high W bits != 0).
  - On completion with the chain flag clear: go to RESULT, display=result.
  - On completion with the chain flag set: A=result, op=held opcode, entry=0, count=0, go to ENTER_B; display=result.
  - eq strobe at edge n: EXEC at n+1. Add/sub: RESULT at n+2. Multiply: RESULT at n+1+W.
- RESULT:
  - newhex: entry=hexcode, count=1, go to ENTER_A, ovf cleared.
  - newop: A=result, op latched, go to ENTER_B, ovf kept.
  - BS or CE: entry=0, count=0, go to ENTER_A, ovf cleared.
  - eq: ignored.
- ovf changes only at EXEC completion, on CA/reset, and on leaving RESULT via newhex, BS or CE.

Test Plan:
- Reset then keys 1,2,3 -> display 0x0001, 0x0012, 0x0123, each one cycle after its strobe; BS -> 0x0012; CE -> 0x0000, state 00.
- 5 digits F,F,F,F,1 with W=16 -> fifth digit ignored, display=0xFFFF.
- 0x0012 + 0x0034, eq -> busy high exactly 1 cycle, display 0x0046, ovf=0, state 11. Repeat with 0xFFFF + 0x0002 -> display 0x0001, ovf=1.
- 0x0003 - 0x0005, eq -> display 0xFFFE, ovf=1.
- 0x0100 * 0x0100, eq -> busy exactly 16 cycles, display 0x0000, ovf=1. Then 0x0012 * 0x0003 -> display 0x0036, ovf=0.
- Chain and abort cases:
  - 2 + 3, then a subtract key -> EXEC, display 0x0005, state 01, op_shown=10.
  - Then 1, eq -> display 0x0004.
  - CA asserted mid-multiply -> next cycle busy=0, display 0, state 00.
  - CA coincident with newhex -> digit ignored.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: control and datapath sequencing for a four-function hex calculator.
// Takes decoded keypad strobes, handles operand entry, operator latching, chained operations
// and the execute phase: single-cycle add/sub, W-cycle shift-add multiply.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   newhex/hexcode       - hex digit strobe and value
//   newop/opcode         - operator strobe and code (00 add, 01 mul, 10 sub, 11 add)
//   eq, BS, CA, CE       - equals, backspace, clear all, clear entry strobes
//   display              - entry, latched operand A, or result
//   busy                 - high while executing
//   ovf                  - overflow/borrow flag of the last operation
//   op_shown, op_valid   - latched operator and "operator pending" flag
//   state                - 00 ENTER_A, 01 ENTER_B, 10 EXEC, 11 RESULT
module calc_sequencer #(
  parameter int unsigned W      = 16,
  parameter int unsigned DIGITS = W / 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         newhex,
  input  logic [3:0]   hexcode,
  input  logic         newop,
  input  logic [1:0]   opcode,
  input  logic         eq,
  input  logic         BS,
  input  logic         CA,
  input  logic         CE,
  output logic [W-1:0] display,
  output logic         busy,
  output logic         ovf,
  output logic [1:0]   op_shown,
  output logic         op_valid,
  output logic [1:0]   state
);

  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned MW = $clog2(W);
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    EXEC    = 2'b10,
    RESULT  = 2'b11
  } state_t;

  state_t          state_q, state_n;
  logic [W-1:0]    entry_q, entry_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [W-1:0]    a_q, a_n;
  logic [W-1:0]    b_q, b_n;
  logic [1:0]      op_n;
  logic [1:0]      hold_q, hold_n;
  logic            chain_q, chain_n;
  logic [W-1:0]    result_q, result_n;
  logic            ovf_n;
  logic [2*W-1:0]  prod_q, prod_n;
  logic [MW-1:0]   mcnt_q, mcnt_n;
  logic [W-1:0]    display_n;
  logic            busy_n;
  logic            op_valid_n;

  logic [W:0]      add_sum;
  logic [W:0]      sub_dif;
  logic [W:0]      step_sum;
  logic [2*W-1:0]  prod_step;
  logic            exec_done;
  logic [W-1:0]    exec_res;
  logic            exec_ovf;

  assign state = state_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ENTER_A;
      entry_q  <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_shown <= '0;
      hold_q   <= '0;
      chain_q  <= 1'b0;
      result_q <= '0;
      ovf      <= 1'b0;
      prod_q   <= '0;
      mcnt_q   <= '0;
      display  <= '0;
      busy     <= 1'b0;
      op_valid <= 1'b0;
    end else begin
      state_q  <= state_n;
      entry_q  <= entry_n;
      cnt_q    <= cnt_n;
      a_q      <= a_n;
      b_q      <= b_n;
      op_shown <= op_n;
      hold_q   <= hold_n;
      chain_q  <= chain_n;
      result_q <= result_n;
      ovf      <= ovf_n;
      prod_q   <= prod_n;
      mcnt_q   <= mcnt_n;
      display  <= display_n;
      busy     <= busy_n;
      op_valid <= op_valid_n;
    end
  end

  // Execute-phase arithmetic; multiply retires one multiplier bit per cycle
  always_comb begin
    add_sum   = {1'b0, a_q} + {1'b0, b_q};
    sub_dif   = {1'b0, a_q} - {1'b0, b_q};
    step_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : (W+1)'(0));
    prod_step = {step_sum, prod_q[W-1:1]};
    exec_done = 1'b1;
    exec_res  = add_sum[W-1:0];
    exec_ovf  = add_sum[W];
    case (op_shown)
      OP_MUL: begin
        exec_done = (mcnt_q == MW'(W - 1));
        exec_res  = prod_step[W-1:0];
        exec_ovf  = |prod_step[2*W-1:W];
      end
      OP_SUB: begin
        exec_res = sub_dif[W-1:0];
        exec_ovf = sub_dif[W];
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic; strobe priority CA > CE > BS > eq > newop > newhex
  always_comb begin
    state_n    = state_q;
    entry_n    = entry_q;
    cnt_n      = cnt_q;
    a_n        = a_q;
    b_n        = b_q;
    op_n       = op_shown;
    hold_n     = hold_q;
    chain_n    = chain_q;
    result_n   = result_q;
    ovf_n      = ovf;
    prod_n     = prod_q;
    mcnt_n     = mcnt_q;
    display_n  = display;

    if (CA) begin
      state_n  = ENTER_A;
      entry_n  = '0;
      cnt_n    = '0;
      a_n      = '0;
      b_n      = '0;
      op_n     = '0;
      hold_n   = '0;
      chain_n  = 1'b0;
      result_n = '0;
      ovf_n    = 1'b0;
      prod_n   = '0;
      mcnt_n   = '0;
    end else begin
      case (state_q)
        ENTER_A, ENTER_B: begin
          if (CE) begin
            entry_n = '0;
            cnt_n   = '0;
          end else if (BS) begin
            if (cnt_q != '0) begin
              entry_n = entry_q >> 4;
              cnt_n   = cnt_q - CW'(1);
            end
          end else if (eq) begin
            if (state_q == ENTER_B) begin
              chain_n = 1'b0;
              b_n     = entry_q;
              prod_n  = {W'(0), entry_q};
              mcnt_n  = '0;
              state_n = EXEC;
            end
          end else if (newop) begin
            if (state_q == ENTER_A) begin
              a_n     = entry_q;
              op_n    = opcode;
              entry_n = '0;
              cnt_n   = '0;
              state_n = ENTER_B;
            end else if (cnt_q == '0) begin
              op_n = opcode;
            end else begin
              // Chained operator: finish the pending op first, then continue with the new one
              chain_n = 1'b1;
              hold_n  = opcode;
              b_n     = entry_q;
              prod_n  = {W'(0), entry_q};
              mcnt_n  = '0;
              state_n = EXEC;
            end
          end else if (newhex) begin
            if (cnt_q < CW'(DIGITS)) begin
              entry_n = {entry_q[W-5:0], hexcode};
              cnt_n   = cnt_q + CW'(1);
            end
          end
        end

        EXEC: begin
          if (!exec_done) begin
            prod_n = prod_step;
            mcnt_n = mcnt_q + MW'(1);
          end else begin
            result_n = exec_res;
            ovf_n    = exec_ovf;
            if (chain_q) begin
              a_n     = exec_res;
              op_n    = hold_q;
              entry_n = '0;
              cnt_n   = '0;
              chain_n = 1'b0;
              state_n = ENTER_B;
            end else begin
              state_n = RESULT;
            end
          end
        end

        RESULT: begin
          if (CE || BS) begin
            entry_n = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
            state_n = ENTER_A;
          end else if (eq) begin
            state_n = RESULT;
          end else if (newop) begin
            a_n     = result_q;
            op_n    = opcode;
            entry_n = '0;
            cnt_n   = '0;
            state_n = ENTER_B;
          end else if (newhex) begin
            entry_n = {W'(0) | W'(hexcode)};
            cnt_n   = CW'(1);
            ovf_n   = 1'b0;
            state_n = ENTER_A;
          end
        end

        default: state_n = ENTER_A;
      endcase
    end

    // Display follows the post-edge state; it holds its value while executing
    case (state_n)
      ENTER_A: display_n = entry_n;
      ENTER_B: display_n = (cnt_n == '0) ? a_n : entry_n;
      RESULT:  display_n = result_n;
      default: display_n = display;
    endcase
    busy_n     = (state_n == EXEC);
    op_valid_n = (state_n == ENTER_B);
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer: directed keypad sequences, a behavioural calculator model
// compared every cycle, and hand-computed literal checks on key results.
module tb_calc_sequencer;

  localparam int unsigned W      = 16;
  localparam int unsigned DIGITS = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         newhex = 1'b0;
  logic [3:0]   hexcode = 4'h0;
  logic         newop = 1'b0;
  logic [1:0]   opcode = 2'b00;
  logic         eq = 1'b0;
  logic         BS = 1'b0;
  logic         CA = 1'b0;
  logic         CE = 1'b0;
  logic [W-1:0] display;
  logic         busy;
  logic         ovf;
  logic [1:0]   op_shown;
  logic         op_valid;
  logic [1:0]   state;

  calc_sequencer #(.W(W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .newhex(newhex), .hexcode(hexcode),
    .newop(newop), .opcode(opcode),
    .eq(eq), .BS(BS), .CA(CA), .CE(CE),
    .display(display), .busy(busy), .ovf(ovf),
    .op_shown(op_shown), .op_valid(op_valid), .state(state)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural calculator model: mode 0 entering A, 1 entering B, 2 executing, 3 showing result
  int           m_mode;
  int           m_cnt;
  int           m_left;
  logic [W-1:0] m_entry, m_a, m_b, m_res, m_disp;
  logic [1:0]   m_op, m_hold;
  bit           m_chain, m_ovf;

  task automatic m_clear();
    m_mode = 0; m_cnt = 0; m_left = 0;
    m_entry = '0; m_a = '0; m_b = '0; m_res = '0; m_disp = '0;
    m_op = '0; m_hold = '0; m_chain = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic m_start();
    m_b    = m_entry;
    m_left = (m_op == 2'b01) ? W : 1;
    m_mode = 2;
  endtask

  task automatic m_finish();
    logic [2*W-1:0] p;
    logic [W:0]     s;
    case (m_op)
      2'b01: begin
        p = (2*W)'(m_a) * (2*W)'(m_b);
        m_res = p[W-1:0];
        m_ovf = (p[2*W-1:W] != '0);
      end
      2'b10: begin
        m_res = m_a - m_b;
        m_ovf = (m_a < m_b);
      end
      default: begin
        s = (W+1)'(m_a) + (W+1)'(m_b);
        m_res = s[W-1:0];
        m_ovf = s[W];
      end
    endcase
    if (m_chain) begin
      m_a = m_res; m_op = m_hold; m_entry = '0; m_cnt = 0; m_chain = 1'b0; m_mode = 1;
    end else begin
      m_mode = 3;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || CA) begin
      m_clear();
    end else begin
      case (m_mode)
        0, 1: begin
          if (CE) begin
            m_entry = '0; m_cnt = 0;
          end else if (BS) begin
            if (m_cnt > 0) begin m_entry = m_entry >> 4; m_cnt--; end
          end else if (eq) begin
            if (m_mode == 1) begin m_chain = 1'b0; m_start(); end
          end else if (newop) begin
            if (m_mode == 0) begin
              m_a = m_entry; m_op = opcode; m_entry = '0; m_cnt = 0; m_mode = 1;
            end else if (m_cnt == 0) begin
              m_op = opcode;
            end else begin
              m_chain = 1'b1; m_hold = opcode; m_start();
            end
          end else if (newhex) begin
            if (m_cnt < DIGITS) begin m_entry = (m_entry << 4) | W'(hexcode); m_cnt++; end
          end
        end
        2: begin
          m_left--;
          if (m_left == 0) m_finish();
        end
        default: begin
          if (CE || BS) begin
            m_entry = '0; m_cnt = 0; m_ovf = 1'b0; m_mode = 0;
          end else if (eq) begin
            m_mode = 3;
          end else if (newop) begin
            m_a = m_res; m_op = opcode; m_entry = '0; m_cnt = 0; m_mode = 1;
          end else if (newhex) begin
            m_entry = W'(hexcode); m_cnt = 1; m_ovf = 1'b0; m_mode = 0;
          end
        end
      endcase
    end
    case (m_mode)
      0: m_disp = m_entry;
      1: m_disp = (m_cnt == 0) ? m_a : m_entry;
      3: m_disp = m_res;
      default: ;
    endcase
  end

  // Every-cycle comparison against the model; display is unspecified while executing
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_state", 32'(state), 32'(m_mode));
      check("m_busy", 32'(busy), 32'(m_mode == 2));
      check("m_op_valid", 32'(op_valid), 32'(m_mode == 1));
      check("m_op_shown", 32'(op_shown), 32'(m_op));
      check("m_ovf", 32'(ovf), 32'(m_ovf));
      if (m_mode != 2) check("m_display", 32'(display), 32'(m_disp));
    end
  end

  task automatic drive(input logic nh, input logic [3:0] hc, input logic no, input logic [1:0] oc,
                       input logic e, input logic bs, input logic ca, input logic ce);
    @(negedge clk);
    newhex = nh; hexcode = hc; newop = no; opcode = oc; eq = e; BS = bs; CA = ca; CE = ce;
    @(negedge clk);
    newhex = 1'b0; hexcode = 4'h0; newop = 1'b0; opcode = 2'b00;
    eq = 1'b0; BS = 1'b0; CA = 1'b0; CE = 1'b0;
  endtask

  task automatic k_hex(input logic [3:0] h);  drive(1'b1, h, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic k_op(input logic [1:0] o);   drive(1'b0, 4'h0, 1'b1, o, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic k_eq();                      drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic k_bs();                      drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic k_ca();                      drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic k_ce();                      drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1); endtask

  // Counts busy cycles from the current negedge; an expired bound is a failure
  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("busy_timeout", 32'(n), 32'd0);
  endtask

  task automatic entry3(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
    k_hex(d0); k_hex(d1); k_hex(d2);
  endtask

  int nb;

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_display", 32'(display), 32'h0);
    check("rst_state", 32'(state), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_op_valid", 32'(op_valid), 32'h0);
    check("rst_op_shown", 32'(op_shown), 32'h0);
    rst_n = 1'b1;

    // Digit entry, backspace, clear entry
    k_hex(4'h1); check("key1", 32'(display), 32'h0001);
    k_hex(4'h2); check("key2", 32'(display), 32'h0012);
    k_hex(4'h3); check("key3", 32'(display), 32'h0123);
    k_bs();      check("bs", 32'(display), 32'h0012);
    k_ce();      check("ce", 32'(display), 32'h0000);
    check("ce_state", 32'(state), 32'h0);
    k_bs();      check("bs_empty", 32'(display), 32'h0000);
    k_eq();      check("eq_in_a", 32'(state), 32'h0);

    // Fifth digit ignored
    k_hex(4'hF); k_hex(4'hF); k_hex(4'hF); k_hex(4'hF); k_hex(4'h1);
    check("five_digits", 32'(display), 32'hFFFF);
    k_ca();

    // 0x12 + 0x34
    k_hex(4'h1); k_hex(4'h2); k_op(2'b00);
    check("opA_valid", 32'(op_valid), 32'h1);
    check("opA_disp", 32'(display), 32'h0012);
    k_hex(4'h3); k_hex(4'h4);
    check("b_disp", 32'(display), 32'h0034);
    k_eq(); wait_busy(nb);
    check("add_busy_cycles", 32'(nb), 32'd1);
    check("add_res", 32'(display), 32'h0046);
    check("add_ovf", 32'(ovf), 32'h0);
    check("add_state", 32'(state), 32'h3);

    // 0xFFFF + 0x0002 carries out
    k_ca();
    k_hex(4'hF); k_hex(4'hF); k_hex(4'hF); k_hex(4'hF); k_op(2'b00); k_hex(4'h2);
    k_eq(); wait_busy(nb);
    check("addc_res", 32'(display), 32'h0001);
    check("addc_ovf", 32'(ovf), 32'h1);

    // 3 - 5 borrows
    k_ca();
    k_hex(4'h3); k_op(2'b10); k_hex(4'h5);
    k_eq(); wait_busy(nb);
    check("sub_res", 32'(display), 32'hFFFE);
    check("sub_ovf", 32'(ovf), 32'h1);

    // 0x100 * 0x100 overflows into the high half
    k_ca();
    entry3(4'h1, 4'h0, 4'h0); k_op(2'b01); entry3(4'h1, 4'h0, 4'h0);
    k_eq(); wait_busy(nb);
    check("mul_busy_cycles", 32'(nb), 32'd16);
    check("mul_res", 32'(display), 32'h0000);
    check("mul_ovf", 32'(ovf), 32'h1);

    // New digit from RESULT clears ovf; then 0x12 * 3
    k_hex(4'h1);
    check("res_hex_ovf", 32'(ovf), 32'h0);
    check("res_hex_state", 32'(state), 32'h0);
    check("res_hex_disp", 32'(display), 32'h0001);
    k_hex(4'h2); k_op(2'b01); k_hex(4'h3);
    k_eq(); wait_busy(nb);
    check("mul2_res", 32'(display), 32'h0036);
    check("mul2_ovf", 32'(ovf), 32'h0);

    // Chained 2 + 3 - 1
    k_ca();
    k_hex(4'h2); k_op(2'b00); k_hex(4'h3); k_op(2'b10);
    check("chain_busy", 32'(busy), 32'h1);
    wait_busy(nb);
    check("chain_disp", 32'(display), 32'h0005);
    check("chain_state", 32'(state), 32'h1);
    check("chain_op", 32'(op_shown), 32'h2);
    k_hex(4'h1); k_eq(); wait_busy(nb);
    check("chain_res", 32'(display), 32'h0004);

    // Operator from RESULT, then replace it before any B digit
    k_op(2'b11);
    check("resop_state", 32'(state), 32'h1);
    check("resop_disp", 32'(display), 32'h0004);
    check("resop_op", 32'(op_shown), 32'h3);
    k_op(2'b01);
    check("replace_op", 32'(op_shown), 32'h1);
    k_hex(4'h2); k_eq(); wait_busy(nb);
    check("replace_res", 32'(display), 32'h0008);

    // Abort mid-multiply
    k_ca();
    k_hex(4'h5); k_op(2'b01); k_hex(4'h3); k_eq();
    repeat (4) @(negedge clk);
    check("abort_pre_busy", 32'(busy), 32'h1);
    k_ca();
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_disp", 32'(display), 32'h0000);
    check("abort_state", 32'(state), 32'h0);

    // Coincident strobes
    k_hex(4'h7);
    drive(1'b1, 4'h5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ca_hex", 32'(display), 32'h0000);
    k_hex(4'h7); k_hex(4'h8);
    drive(1'b1, 4'h9, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("bs_hex", 32'(display), 32'h0007);
    drive(1'b0, 4'h0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ce_op_state", 32'(state), 32'h0);
    check("ce_op_disp", 32'(display), 32'h0000);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
